// File: rtl/msend_pkg.sv
// msend_pkg: shared state encoding and sizing helpers for the serial frame transmitter.
package msend_pkg;

    typedef enum logic [2:0] {IDLE, DATA, CRC, SEP, TAIL} state_t;

    function automatic int nbits(input int dw, input int cw, input int tw);
        return dw + cw + 1 + tw;
    endfunction

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msend_frame_crc_serial.sv
// crc_serial: bit-serial CRC LFSR, one data bit per valid strobe, cleared at frame start.
module crc_serial #(
    parameter int                CRC_W    = 10,
    parameter logic [CRC_W-1:0]  CRC_POLY = 10'h233
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             valid,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ din;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (valid)
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end

endmodule

// File: rtl/msend_frame.sv
// msend_frame: buffered serial frame sender - data MSB-first, CRC, a zero separator, then idle ones.
module msend_frame
    import msend_pkg::*;
#(
    parameter int               DATA_W   = 24,
    parameter int               CRC_W    = 10,
    parameter logic [CRC_W-1:0] CRC_POLY = 10'h233,
    parameter int               TAIL_W   = 14,
    parameter int               BIT_CLKS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              unit_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              sending,
    output logic              frame_done,
    output logic              sent
);

    localparam int NBITS = nbits(DATA_W, CRC_W, TAIL_W);
    localparam int BW    = cnt_w(NBITS);
    localparam int PW    = cnt_w(BIT_CLKS);
    localparam int SH_W  = (DATA_W > CRC_W) ? DATA_W : CRC_W;

    state_t            state, state_nx;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic [SH_W-1:0]   sh;
    logic [BW-1:0]     bitc;
    logic [PW-1:0]     phase;
    logic [CRC_W-1:0]  crc;
    logic              last_ph, load, dout;

    assign last_ph = phase == PW'(BIT_CLKS - 1);
    assign s_ready = !hold_full;
    assign sending = state != IDLE;
    assign sent    = unit_en & dout;

    always_comb begin
        state_nx   = state;
        dout       = 1'b1;
        frame_done = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                state_nx = hold_full ? DATA : IDLE;
                load     = hold_full;
            end
            DATA: begin
                dout = sh[SH_W-1];
                if (last_ph && bitc == BW'(DATA_W - 1)) state_nx = CRC;
            end
            CRC: begin
                dout = sh[SH_W-1];
                if (last_ph && bitc == BW'(DATA_W + CRC_W - 1)) state_nx = SEP;
            end
            SEP: begin
                dout = 1'b0;
                if (last_ph) state_nx = TAIL;
            end
            TAIL: begin
                // Last clock of the frame: chain straight into a held word if there is one.
                if (last_ph && bitc == BW'(NBITS - 1)) begin
                    frame_done = 1'b1;
                    state_nx   = hold_full ? DATA : IDLE;
                    load       = hold_full;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (s_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= s_data;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh    <= '0;
            bitc  <= '0;
            phase <= '0;
        end else if (load) begin
            sh    <= SH_W'(hold_data) << (SH_W - DATA_W);
            bitc  <= '0;
            phase <= '0;
        end else if (state != IDLE) begin
            phase <= last_ph ? '0 : phase + 1'b1;
            if (last_ph) begin
                bitc <= bitc + 1'b1;
                sh   <= (state == DATA && bitc == BW'(DATA_W - 1)) ? SH_W'(crc) << (SH_W - CRC_W) : sh << 1;
            end
        end
    end

    crc_serial #(.CRC_W(CRC_W), .CRC_POLY(CRC_POLY)) u_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (load),
        .valid(state == DATA && phase == '0),
        .din  (sh[SH_W-1]),
        .crc  (crc)
    );

endmodule
